// File: rtl/arb_mux_n_if.sv
// Handshake bundle for arb_mux_n: N_IN valid/ready/data sources in, one valid/ready/data/src out.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

interface arb_mux_n_if #(
    parameter int unsigned WIDTH = `ARCH_WIDTH,
    parameter int unsigned N_IN  = 4
);
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;

    // Producers and the downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // The arbitrating mux.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/arb_mux_n.sv
// N-input arbitrating mux with a single registered output stage; round-robin by default,
// fixed lowest-index priority when ARB_MUX_FIXED_PRIO_EN is defined.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

module arb_mux_n #(
    parameter int unsigned WIDTH = `ARCH_WIDTH,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input logic        clk,
    input logic        rst,
    arb_mux_n_if.slave bus
);
    localparam logic [SEL_W:0] N_IN_EXT = (SEL_W + 1)'(N_IN);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W:0]   scan;
    logic [N_IN-1:0]  grant;
    logic [WIDTH-1:0] win_data;
    logic             any_valid;
    logic             load_ok;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

    // First valid channel at or above ptr, wrapping modulo N_IN.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        scan      = '0;
        win_data  = '0;
        for (int k = 0; k < N_IN; k++) begin
            scan = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (scan >= N_IN_EXT) begin
                scan = scan - N_IN_EXT;
            end
            if (!any_valid && bus.in_valid[scan[SEL_W-1:0]]) begin
                any_valid = 1'b1;
                win_idx   = scan[SEL_W-1:0];
            end
        end
        if (any_valid) begin
            grant[win_idx] = 1'b1;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_ok      = !out_valid_q || bus.out_ready;
    assign xfer         = any_valid && load_ok;
    assign bus.in_ready = rst ? '0 : (grant & {N_IN{load_ok}});

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_src_d   = win_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;

    assign ptr_d = (win_idx == SEL_W'(N_IN - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    // A pending request must hold its valid and data until it is accepted.
    for (genvar i = 0; i < N_IN; i++) begin : g_src_chk
        src_hold_a: assert property (@(posedge clk) disable iff (rst)
            (bus.in_valid[i] && !bus.in_ready[i]) |=>
            (rst || (bus.in_valid[i] && $stable(bus.in_data[i*WIDTH +: WIDTH]))));
    end
endmodule
